// File: rtl/dispatch_queue_pkg.sv
// rtl/dispatch_queue_pkg.sv - shared types, RS tags and class helpers for the dispatch queue
package dispatch_queue_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    FU_ALU,
    FU_LOAD,
    FU_STORE
  } fu_class_t;

  typedef logic [2:0] RS_tag_type;

  // RS_BUSY / avail bit order: ALU1, ALU2, LOAD, STORE
  localparam RS_tag_type INVALID = 3'd0;
  localparam RS_tag_type ALU1_RS = 3'd1;
  localparam RS_tag_type ALU2_RS = 3'd2;
  localparam RS_tag_type LD_RS   = 3'd3;
  localparam RS_tag_type ST_RS   = 3'd4;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [3:0]  alu_fun;
    logic [2:0]  mem_type;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] rs2_data;
  } task_t;

  function automatic logic [3:0] rs_onehot(input RS_tag_type tag);
    case (tag)
      ALU1_RS: rs_onehot = 4'b0001;
      ALU2_RS: rs_onehot = 4'b0010;
      LD_RS:   rs_onehot = 4'b0100;
      ST_RS:   rs_onehot = 4'b1000;
      default: rs_onehot = 4'b0000;
    endcase
  endfunction

  function automatic fu_class_t fu_class_of(input logic [6:0] opcode);
    if (opcode == OP_LOAD)
      fu_class_of = FU_LOAD;
    else if (opcode == OP_STORE)
      fu_class_of = FU_STORE;
    else
      fu_class_of = FU_ALU;
  endfunction

endpackage

// File: rtl/dispatch_queue_rs_select.sv
// rtl/dispatch_queue_rs_select.sv - picks a free reservation station for a functional-unit class
module rs_select
  import dispatch_queue_pkg::*;
(
  input  fu_class_t  fu_class,
  input  logic [3:0] avail,
  output RS_tag_type tag,
  output logic       found
);

  always_comb begin
    tag   = INVALID;
    found = 1'b0;
    case (fu_class)
      FU_ALU: begin
        // ALU1 is preferred; ALU2 only takes work when ALU1 is unavailable
        if (avail[0]) begin
          tag   = ALU1_RS;
          found = 1'b1;
        end else if (avail[1]) begin
          tag   = ALU2_RS;
          found = 1'b1;
        end
      end
      FU_LOAD: begin
        if (avail[2]) begin
          tag   = LD_RS;
          found = 1'b1;
        end
      end
      FU_STORE: begin
        if (avail[3]) begin
          tag   = ST_RS;
          found = 1'b1;
        end
      end
      default: begin
        tag   = INVALID;
        found = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dispatch_queue.sv
// rtl/dispatch_queue.sv - in-order issue queue dispatching decoded tasks to reservation stations
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             FLUSH,
  input  logic             ENQ_VALID,
  input  task_t            ENQ_TASK,
  output logic             ENQ_READY,
  input  logic [3:0]       RS_BUSY,
  output task_t            DISPATCH_TASK,
  output RS_tag_type       dest_RS,
  output logic [CNT_W-1:0] COUNT
);

  localparam int PTR_W = $clog2(DEPTH);

  task_t            mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [3:0]       last_sel;

  logic       full;
  logic       empty;
  task_t      head_task;
  fu_class_t  head_class;
  logic [3:0] avail;
  RS_tag_type sel_tag;
  logic       sel_found;
  logic       enq;
  logic       deq;

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign head_task  = mem[head];
  assign head_class = fu_class_of(head_task.opcode);

  // An RS dispatched to last cycle may not have raised BUSY yet, so skip it once
  assign avail = ~RS_BUSY & ~last_sel;

  rs_select u_rs_select (
    .fu_class (head_class),
    .avail    (avail),
    .tag      (sel_tag),
    .found    (sel_found)
  );

  assign enq = ENQ_VALID && !full && !FLUSH;
  assign deq = sel_found && !empty && !FLUSH;

  assign ENQ_READY = !full;
  assign COUNT     = count;

  always_ff @(posedge CLK) begin
    if (enq)
      mem[tail] <= ENQ_TASK;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      last_sel      <= '0;
      dest_RS       <= INVALID;
      DISPATCH_TASK <= '0;
    end else if (FLUSH) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      last_sel <= '0;
      dest_RS  <= INVALID;
    end else begin
      if (enq)
        tail <= tail + PTR_W'(1);
      if (deq) begin
        head          <= head + PTR_W'(1);
        DISPATCH_TASK <= head_task;
        dest_RS       <= sel_tag;
        last_sel      <= rs_onehot(sel_tag);
      end else begin
        dest_RS  <= INVALID;
        last_sel <= '0;
      end
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// tb/tb_dispatch_queue.sv - self-checking bench for dispatch_queue with a queue-based reference model
module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       FLUSH;
  logic       ENQ_VALID;
  task_t      ENQ_TASK;
  logic       ENQ_READY;
  logic [3:0] RS_BUSY;
  task_t      DISPATCH_TASK;
  RS_tag_type dest_RS;
  logic [3:0] COUNT;

  int n_checks = 0;
  int n_fail   = 0;

  dispatch_queue #(.DEPTH(DEPTH)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .FLUSH         (FLUSH),
    .ENQ_VALID     (ENQ_VALID),
    .ENQ_TASK      (ENQ_TASK),
    .ENQ_READY     (ENQ_READY),
    .RS_BUSY       (RS_BUSY),
    .DISPATCH_TASK (DISPATCH_TASK),
    .dest_RS       (dest_RS),
    .COUNT         (COUNT)
  );

  always #5 CLK = ~CLK;

  function automatic task_t mk(input logic [6:0] op, input logic [31:0] a);
    task_t t;
    t          = '0;
    t.opcode   = op;
    t.alu_fun  = a[3:0];
    t.mem_type = a[2:0];
    t.A        = a;
    t.B        = a ^ 32'hA5A5_0000;
    t.rs2_data = a + 32'd1;
    return t;
  endfunction

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST_N = 1'b0; FLUSH = 1'b0; ENQ_VALID = 1'b0; ENQ_TASK = '0; RS_BUSY = 4'h0;
    repeat (2) tick();
    RST_N = 1'b1;
    tick();
    n_checks++;
    if (ENQ_READY !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ENQ_READY); end
    n_checks++;
    if (COUNT !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", COUNT); end
    n_checks++;
    if (dest_RS !== INVALID) begin n_fail++; $display("FAIL reset_dest got %0d want %0d", dest_RS, INVALID); end
    n_checks++;
    if (DISPATCH_TASK !== task_t'('0)) begin n_fail++; $display("FAIL reset_task got %h want 0", DISPATCH_TASK); end
  endtask

  task automatic test_single_enqueue();
    ENQ_VALID = 1'b1; ENQ_TASK = mk(OP_ADD, 32'd5);
    tick();
    ENQ_VALID = 1'b0;
    n_checks++;
    if (COUNT !== 4'd1 || dest_RS !== INVALID) begin
      n_fail++; $display("FAIL single_nopass got count %0d dest %0d want 1 %0d", COUNT, dest_RS, INVALID);
    end
    tick();
    n_checks++;
    if (dest_RS !== ALU1_RS) begin n_fail++; $display("FAIL single_dest got %0d want %0d", dest_RS, ALU1_RS); end
    n_checks++;
    if (DISPATCH_TASK.A !== 32'd5 || DISPATCH_TASK.B !== (32'd5 ^ 32'hA5A5_0000)) begin
      n_fail++; $display("FAIL single_ab got %h/%h want %h/%h", DISPATCH_TASK.A, DISPATCH_TASK.B, 32'd5, 32'd5 ^ 32'hA5A5_0000);
    end
    n_checks++;
    if (COUNT !== 4'd0) begin n_fail++; $display("FAIL single_count got %0d want 0", COUNT); end
    tick();
    n_checks++;
    if (dest_RS !== INVALID) begin n_fail++; $display("FAIL single_idle got %0d want %0d", dest_RS, INVALID); end
  endtask

  task automatic test_alu_spread();
    RST_N_T: begin end
    RS_BUSY = 4'h0;
    ENQ_VALID = 1'b1; ENQ_TASK = mk(OP_ADD, 32'd10);
    tick();
    ENQ_TASK = mk(OP_ADD, 32'd11);
    tick();
    n_checks++;
    if (dest_RS !== ALU1_RS || DISPATCH_TASK.A !== 32'd10) begin
      n_fail++; $display("FAIL spread_0 got %0d A=%0d want %0d A=10", dest_RS, DISPATCH_TASK.A, ALU1_RS);
    end
    ENQ_TASK = mk(OP_ADD, 32'd12);
    tick();
    ENQ_VALID = 1'b0;
    n_checks++;
    if (dest_RS !== ALU2_RS || DISPATCH_TASK.A !== 32'd11) begin
      n_fail++; $display("FAIL spread_1 got %0d A=%0d want %0d A=11", dest_RS, DISPATCH_TASK.A, ALU2_RS);
    end
    tick();
    n_checks++;
    if (dest_RS !== ALU1_RS || DISPATCH_TASK.A !== 32'd12) begin
      n_fail++; $display("FAIL spread_2 got %0d A=%0d want %0d A=12", dest_RS, DISPATCH_TASK.A, ALU1_RS);
    end
    tick();
  endtask

  task automatic test_in_order_blocking();
    RS_BUSY = 4'b0100;
    ENQ_VALID = 1'b1; ENQ_TASK = mk(OP_LOAD, 32'd20);
    tick();
    ENQ_TASK = mk(OP_ADD, 32'd21);
    tick();
    ENQ_VALID = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (COUNT !== 4'd2 || dest_RS !== INVALID) begin
      n_fail++; $display("FAIL block_hold got count %0d dest %0d want 2 %0d", COUNT, dest_RS, INVALID);
    end
    RS_BUSY = 4'b0000;
    tick();
    n_checks++;
    if (dest_RS !== LD_RS || DISPATCH_TASK.A !== 32'd20) begin
      n_fail++; $display("FAIL block_ld got %0d A=%0d want %0d A=20", dest_RS, DISPATCH_TASK.A, LD_RS);
    end
    tick();
    n_checks++;
    if (dest_RS !== ALU1_RS || DISPATCH_TASK.A !== 32'd21) begin
      n_fail++; $display("FAIL block_alu got %0d A=%0d want %0d A=21", dest_RS, DISPATCH_TASK.A, ALU1_RS);
    end
    tick();
  endtask

  task automatic fill_and_drain(input logic [31:0] base);
    RS_BUSY = 4'hF;
    ENQ_VALID = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      ENQ_TASK = mk(OP_ADD, base + 32'(i));
      tick();
    end
    n_checks++;
    if (ENQ_READY !== 1'b0 || COUNT !== 4'd8) begin
      n_fail++; $display("FAIL full_state got ready %b count %0d want 0 8", ENQ_READY, COUNT);
    end
    ENQ_TASK = mk(OP_ADD, 32'd99);
    tick();
    ENQ_VALID = 1'b0;
    n_checks++;
    if (COUNT !== 4'd8) begin n_fail++; $display("FAIL full_ignore got %0d want 8", COUNT); end
    RS_BUSY = 4'h0;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      n_checks++;
      if (dest_RS === INVALID || DISPATCH_TASK.A !== base + 32'(i)) begin
        n_fail++; $display("FAIL drain_%0d got dest %0d A=%0d want valid A=%0d", i, dest_RS, DISPATCH_TASK.A, base + 32'(i));
      end
      if (i == 0) begin
        n_checks++;
        if (ENQ_READY !== 1'b1) begin n_fail++; $display("FAIL full_release got %b want 1", ENQ_READY); end
      end
    end
    tick();
    n_checks++;
    if (dest_RS !== INVALID || COUNT !== 4'd0) begin
      n_fail++; $display("FAIL drain_end got dest %0d count %0d want %0d 0", dest_RS, COUNT, INVALID);
    end
  endtask

  task automatic test_full_wrap();
    fill_and_drain(32'd0);
    fill_and_drain(32'd100);
  endtask

  task automatic test_flush();
    RS_BUSY = 4'hF;
    ENQ_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ENQ_TASK = mk(OP_ADD, 32'd200 + 32'(i));
      tick();
    end
    ENQ_VALID = 1'b0;
    n_checks++;
    if (COUNT !== 4'd5) begin n_fail++; $display("FAIL flush_pre got %0d want 5", COUNT); end
    FLUSH = 1'b1; ENQ_VALID = 1'b1; ENQ_TASK = mk(OP_ADD, 32'd77); RS_BUSY = 4'h0;
    tick();
    FLUSH = 1'b0; ENQ_VALID = 1'b0;
    n_checks++;
    if (COUNT !== 4'd0 || dest_RS !== INVALID) begin
      n_fail++; $display("FAIL flush_clear got count %0d dest %0d want 0 %0d", COUNT, dest_RS, INVALID);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (dest_RS !== INVALID || COUNT !== 4'd0) begin
        n_fail++; $display("FAIL flush_drop_%0d got dest %0d count %0d want %0d 0", i, dest_RS, COUNT, INVALID);
      end
    end
  endtask

  task automatic test_async_reset();
    RS_BUSY = 4'hF;
    ENQ_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ENQ_TASK = mk(OP_ADD, 32'd300 + 32'(i));
      tick();
    end
    ENQ_VALID = 1'b0; RS_BUSY = 4'h0;
    tick();
    n_checks++;
    if (dest_RS !== ALU1_RS) begin n_fail++; $display("FAIL areset_pre got %0d want %0d", dest_RS, ALU1_RS); end
    #2 RST_N = 1'b0;
    #1;
    n_checks++;
    if (dest_RS !== INVALID || COUNT !== 4'd0 || ENQ_READY !== 1'b1 || DISPATCH_TASK !== task_t'('0)) begin
      n_fail++; $display("FAIL areset_now got dest %0d count %0d ready %b task %h want %0d 0 1 0",
                         dest_RS, COUNT, ENQ_READY, DISPATCH_TASK, INVALID);
    end
    #1 RST_N = 1'b1;
    tick();
    n_checks++;
    if (dest_RS !== INVALID || COUNT !== 4'd0) begin
      n_fail++; $display("FAIL areset_after got dest %0d count %0d want %0d 0", dest_RS, COUNT, INVALID);
    end
  endtask

  // Reference: a task list in program order plus the tag dispatched last cycle
  task automatic test_random();
    task_t      q[$];
    task_t      last_task;
    task_t      t;
    RS_tag_type last_tag;
    RS_tag_type exp_tag;
    logic [6:0] ops [4];
    logic [3:0] busy;
    logic       en;
    logic       accepted;
    ops[0] = OP_LOAD; ops[1] = OP_STORE; ops[2] = OP_ADD; ops[3] = OP_ADDI;
    last_task = '0;
    last_tag  = INVALID;
    for (int c = 0; c < 400; c++) begin
      en   = ($urandom_range(0, 99) < 55);
      t    = mk(ops[$urandom_range(0, 3)], $urandom);
      busy = 4'($urandom & $urandom);
      exp_tag = INVALID;
      if (q.size() > 0) begin
        if (q[0].opcode == OP_LOAD) begin
          if (!busy[2] && last_tag != LD_RS) exp_tag = LD_RS;
        end else if (q[0].opcode == OP_STORE) begin
          if (!busy[3] && last_tag != ST_RS) exp_tag = ST_RS;
        end else begin
          if (!busy[0] && last_tag != ALU1_RS) exp_tag = ALU1_RS;
          else if (!busy[1] && last_tag != ALU2_RS) exp_tag = ALU2_RS;
        end
      end
      accepted = en && (q.size() < DEPTH);
      ENQ_VALID = en; ENQ_TASK = t; RS_BUSY = busy;
      tick();
      if (exp_tag != INVALID) last_task = q.pop_front();
      if (accepted) q.push_back(t);
      last_tag = exp_tag;
      n_checks++;
      if (dest_RS !== exp_tag) begin
        n_fail++; $display("FAIL rand_dest cycle %0d got %0d want %0d", c, dest_RS, exp_tag);
      end
      n_checks++;
      if (DISPATCH_TASK !== last_task) begin
        n_fail++; $display("FAIL rand_task cycle %0d got %h want %h", c, DISPATCH_TASK, last_task);
      end
      n_checks++;
      if (COUNT !== 4'(q.size()) || ENQ_READY !== (q.size() < DEPTH)) begin
        n_fail++; $display("FAIL rand_count cycle %0d got %0d/%b want %0d/%b", c, COUNT, ENQ_READY, q.size(), q.size() < DEPTH);
      end
    end
    ENQ_VALID = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_enqueue();
    test_alu_spread();
    test_in_order_blocking();
    test_full_wrap();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
